// File: rtl/trace_event_if.sv
// Bundles the per-core trace event inputs and the merged output stream.
// The master side belongs to the cores and the sink. The slave side belongs to the arbiter.
interface trace_event_if #(
    parameter int NUM_REQ    = 9,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8
);
    localparam int CNT_W = $clog2(NUM_REQ + 1);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_term;
    logic [NUM_REQ-1:0]            req_overflow;
    logic                          out_valid;
    logic                          out_ready;
    logic [ID_WIDTH-1:0]           out_id;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [CNT_W-1:0]              term_count;
    logic                          all_done;

    modport master (
        output req_valid, req_data, req_term, out_ready,
        input  req_overflow, out_valid, out_id, out_data, term_count, all_done
    );

    modport slave (
        input  req_valid, req_data, req_term, out_ready,
        output req_overflow, out_valid, out_id, out_data, term_count, all_done
    );
endinterface

// File: rtl/trace_event_arbiter.sv
// Merges one-cycle trace event pulses from NUM_REQ cores onto a single
// valid/ready stream. Each core has a one-deep hold slot, and the slots are
// served round-robin. The block tracks which cores have terminated and raises
// all_done once every core has terminated and every held event has been sent.
module trace_event_arbiter #(
    parameter int NUM_REQ    = 9,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8
) (
    input  logic          clk,
    input  logic          rst,
    trace_event_if.slave  bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(NUM_REQ + 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    fsm_done;

    logic [NUM_REQ-1:0]      hold_v;
    logic [DATA_WIDTH-1:0]   hold_d [NUM_REQ];
    logic [PTR_W-1:0]        ptr;
    logic [NUM_REQ-1:0]      term_seen;
    logic [NUM_REQ-1:0]      overflow_q;
    logic [CNT_W-1:0]        term_count_q;
    logic [CNT_W-1:0]        term_pop;

    logic                    out_valid_q;
    logic [ID_WIDTH-1:0]     out_id_q;
    logic [DATA_WIDTH-1:0]   out_data_q;

    logic                    load;
    logic                    grant_found;
    logic [PTR_W-1:0]        grant_idx;
    logic [PTR_W:0]          cand;
    logic [NUM_REQ-1:0]      drain_mask;
    logic [NUM_REQ-1:0]      accept;
    logic [NUM_REQ-1:0]      drop;

    assign load = !out_valid_q || bus.out_ready;

    // Round-robin search: first held slot after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_found && hold_v[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Decide which slot is drained and which new pulses are captured or dropped.
    always_comb begin
        drain_mask = '0;
        if (load && grant_found) begin
            drain_mask[grant_idx] = 1'b1;
        end
        // A slot emptied this cycle can take a new pulse. Once done, every pulse is refused.
        accept = bus.req_valid & ~{NUM_REQ{fsm_done}} & (~hold_v | drain_mask);
        drop   = bus.req_valid & ~accept;
    end

    // Per-core hold slots.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (rst) begin
            hold_v <= '0;
            // NOTE: the payload slots are cleared on reset so no stale payload survives. They are only NUM_REQ words.
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_d[i] <= '0;
            end
        end else begin
            hold_v <= (hold_v & ~drain_mask) | accept;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    hold_d[i] <= bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Output register and round-robin pointer. Both hold steady while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
            ptr         <= PTR_W'(NUM_REQ - 1);
        end else if (load) begin
            if (grant_found) begin
                out_valid_q <= 1'b1;
                out_id_q    <= ID_WIDTH'(grant_idx);
                out_data_q  <= hold_d[grant_idx];
                ptr         <= grant_idx;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Popcount of the terminated cores.
    always_comb begin
        term_pop = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            term_pop = term_pop + CNT_W'(term_seen[i]);
        end
    end

    // Sticky overflow and termination flags, plus the registered term count.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q   <= '0;
            term_seen    <= '0;
            term_count_q <= '0;
        end else begin
            overflow_q   <= overflow_q | drop;
            term_seen    <= term_seen | bus.req_term;
            term_count_q <= term_pop;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: RUN until all cores terminate, DRAIN until empty, then DONE (absorbing).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN:   if (&term_seen) state_d = S_DRAIN;
            S_DRAIN: if (hold_v == '0 && !out_valid_q) state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_RUN;
        endcase
    end

    // FSM outputs: all_done comes straight from the state register.
    always_comb begin
        fsm_done = (state_q == S_DONE);
    end

    assign bus.req_overflow = overflow_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_id       = out_id_q;
    assign bus.out_data     = out_data_q;
    assign bus.term_count   = term_count_q;
    assign bus.all_done     = fsm_done;

endmodule

// File: tb/tb_trace_event_arbiter.sv
// Bench for trace_event_arbiter. It runs directed scenarios followed by a randomized run.
// The randomized run is compared against a behavioural model that works on integer arrays.
module tb_trace_event_arbiter;
    localparam int NR    = 9;
    localparam int DW    = 32;
    localparam int IW    = 8;
    localparam int CNT_W = $clog2(NR + 1);

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    trace_event_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    trace_event_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: pending flag and payload per core, plus output and bookkeeping state.
    bit          m_pend  [NR];
    logic [DW-1:0] m_pdata [NR];
    int          m_ptr;
    logic [NR-1:0] m_ovf;
    logic [NR-1:0] m_term;
    int          m_tcount;
    bit          m_ov;
    int          m_oid;
    logic [DW-1:0] m_odata;
    int          m_phase;   // 0 = running, 1 = draining, 2 = finished

    function automatic void model_step();
        int  winner;
        int  old_phase;
        bit  any_pend;
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                m_pend[i]  = 0;
                m_pdata[i] = '0;
            end
            m_ptr = NR - 1; m_ovf = '0; m_term = '0; m_tcount = 0;
            m_ov = 0; m_oid = 0; m_odata = '0; m_phase = 0;
            return;
        end
        old_phase = m_phase;
        any_pend  = 0;
        for (int i = 0; i < NR; i++) any_pend |= m_pend[i];
        if (m_phase == 0 && m_term == {NR{1'b1}}) m_phase = 1;
        else if (m_phase == 1 && !any_pend && !m_ov) m_phase = 2;
        m_tcount = $countones(m_term);
        winner = -1;
        if (!m_ov || bus.out_ready) begin
            for (int k = 1; k <= NR; k++) begin
                if (m_pend[(m_ptr + k) % NR]) begin
                    winner = (m_ptr + k) % NR;
                    break;
                end
            end
            if (winner >= 0) begin
                m_ov = 1; m_oid = winner; m_odata = m_pdata[winner];
                m_ptr = winner; m_pend[winner] = 0;
            end else begin
                m_ov = 0;
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (bus.req_valid[i]) begin
                if (old_phase == 2 || m_pend[i]) m_ovf[i] = 1'b1;
                else begin
                    m_pend[i]  = 1;
                    m_pdata[i] = bus.req_data[i*DW +: DW];
                end
            end
        end
        m_term = m_term | bus.req_term;
    endfunction

    // One clock: the model advances on the rising edge, and the caller samples on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_term  = '0;
    endtask

    task automatic pulse(input int core, input logic [DW-1:0] data);
        bus.req_valid[core]           = 1'b1;
        bus.req_data[core*DW +: DW]   = data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        bus.out_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.out_ready = 1'b0;
        do_reset();
        n_checks++;
        if ({bus.out_valid, bus.out_id, bus.out_data, bus.req_overflow, bus.term_count, bus.all_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b id=%0d data=%h ovf=%b tc=%0d done=%b, all zero required",
                     bus.out_valid, bus.out_id, bus.out_data, bus.req_overflow, bus.term_count, bus.all_done);
        end
    endtask

    task automatic test_single_latency();
        do_reset();
        pulse(3, 32'h41);
        tick();                // cycle 1
        clear_inputs();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL lat_cycle1_valid: got %b want 0", bus.out_valid);
        end
        tick();                // cycle 2
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== IW'(3) || bus.out_data !== 32'h41) begin
            n_fail++;
            $display("FAIL lat_cycle2_event: got v=%b id=%0d data=%h want v=1 id=3 data=41",
                     bus.out_valid, bus.out_id, bus.out_data);
        end
        tick();                // cycle 3
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL lat_cycle3_valid: got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_all_cores();
        do_reset();
        for (int i = 0; i < NR; i++) pulse(i, DW'(i));
        tick();
        clear_inputs();
        for (int c = 0; c < NR; c++) begin
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_id !== IW'(c) || bus.out_data !== DW'(c)) begin
                n_fail++;
                $display("FAIL all_cores_seq: got v=%b id=%0d data=%0d want v=1 id=%0d data=%0d",
                         bus.out_valid, bus.out_id, bus.out_data, c, c);
            end
        end
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.req_overflow !== '0) begin
            n_fail++;
            $display("FAIL all_cores_end: got v=%b ovf=%b want v=0 ovf=0", bus.out_valid, bus.req_overflow);
        end
    endtask

    task automatic test_overflow();
        int got_core2;
        do_reset();
        bus.out_ready = 1'b0;
        pulse(7, 32'h99);      // fills the output register
        tick();
        clear_inputs();
        pulse(2, 32'h10);      // held in the slot
        tick();
        clear_inputs();
        pulse(2, 32'h11);      // slot full and output stalled: dropped
        tick();
        clear_inputs();
        tick();
        n_checks++;
        if (bus.req_overflow !== NR'(1 << 2)) begin
            n_fail++; $display("FAIL ovf_flag: got %b want %b", bus.req_overflow, NR'(1 << 2));
        end
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== IW'(7) || bus.out_data !== 32'h99) begin
            n_fail++;
            $display("FAIL ovf_stall_hold: got v=%b id=%0d data=%h want v=1 id=7 data=99",
                     bus.out_valid, bus.out_id, bus.out_data);
        end
        bus.out_ready = 1'b1;
        got_core2 = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.out_valid && bus.out_id == IW'(2)) begin
                got_core2++;
                n_checks++;
                if (bus.out_data !== 32'h10) begin
                    n_fail++; $display("FAIL ovf_kept_data: got %h want 10", bus.out_data);
                end
            end
        end
        n_checks++;
        if (got_core2 !== 1) begin
            n_fail++; $display("FAIL ovf_event_count: got %0d events from core 2 want 1", got_core2);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            clear_inputs();
            if (k < 8) begin
                pulse(0, 32'hA0 + DW'(k));
                pulse(1, 32'hB0 + DW'(k));
            end
            tick();            // now in cycle k+1
            if (k + 1 >= 2) begin
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_id !== IW'((k - 1) % 2)) begin
                    n_fail++;
                    $display("FAIL b2b_alternate: cycle %0d got v=%b id=%0d want v=1 id=%0d",
                             k + 1, bus.out_valid, bus.out_id, (k - 1) % 2);
                end
            end
        end
        clear_inputs();
        n_checks++;
        if (bus.req_overflow[1:0] !== 2'b11) begin
            n_fail++; $display("FAIL b2b_overflow: got %b want 11", bus.req_overflow[1:0]);
        end
    endtask

    task automatic test_termination();
        int waited;
        do_reset();
        bus.out_ready = 1'b0;
        pulse(5, 32'h55);
        tick();
        clear_inputs();
        bus.req_term = '1;
        tick();
        bus.req_term = 3'b101;   // repeat pulses must not recount
        tick();
        clear_inputs();
        tick();
        n_checks++;
        if (bus.term_count !== CNT_W'(9) || bus.all_done !== 1'b0) begin
            n_fail++;
            $display("FAIL term_count_pending: got tc=%0d done=%b want tc=9 done=0", bus.term_count, bus.all_done);
        end
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== IW'(5) || bus.out_data !== 32'h55) begin
            n_fail++;
            $display("FAIL term_held_event: got v=%b id=%0d data=%h want v=1 id=5 data=55",
                     bus.out_valid, bus.out_id, bus.out_data);
        end
        bus.out_ready = 1'b1;
        waited = 0;
        while (bus.all_done !== 1'b1 && waited < 4) begin
            tick();
            waited++;
        end
        n_checks++;
        if (bus.all_done !== 1'b1 || waited > 2) begin
            n_fail++;
            $display("FAIL term_all_done: got done=%b after %0d cycles want done=1 within 2", bus.all_done, waited);
        end
        pulse(4, 32'h77);
        tick();
        clear_inputs();
        tick();
        n_checks++;
        if (bus.req_overflow[4] !== 1'b1 || bus.out_valid !== 1'b0 || bus.all_done !== 1'b1) begin
            n_fail++;
            $display("FAIL term_done_drop: got ovf4=%b v=%b done=%b want ovf4=1 v=0 done=1",
                     bus.req_overflow[4], bus.out_valid, bus.all_done);
        end
    endtask

    task automatic test_reset_midflight();
        int stale;
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) pulse(i, 32'hC0 + DW'(i));
        bus.req_term[0] = 1'b1;
        tick();
        clear_inputs();
        pulse(1, 32'hDD);        // core 1 still held: dropped
        tick();
        clear_inputs();
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.req_overflow === '0 || bus.term_count === '0) begin
            n_fail++;
            $display("FAIL rst_setup: got v=%b ovf=%b tc=%0d want v=1 ovf!=0 tc!=0",
                     bus.out_valid, bus.req_overflow, bus.term_count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.out_id, bus.out_data, bus.req_overflow, bus.term_count, bus.all_done} !== '0) begin
            n_fail++;
            $display("FAIL rst_midflight_zero: valid=%b id=%0d data=%h ovf=%b tc=%0d done=%b, all zero required",
                     bus.out_valid, bus.out_id, bus.out_data, bus.req_overflow, bus.term_count, bus.all_done);
        end
        bus.out_ready = 1'b1;
        pulse(8, 32'h88);
        tick();
        clear_inputs();
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== IW'(8) || bus.out_data !== 32'h88) begin
            n_fail++;
            $display("FAIL rst_fresh_event: got v=%b id=%0d data=%h want v=1 id=8 data=88",
                     bus.out_valid, bus.out_id, bus.out_data);
        end
        stale = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.out_valid) stale++;
        end
        n_checks++;
        if (stale !== 0) begin
            n_fail++; $display("FAIL rst_no_stale: got %0d stale events want 0", stale);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            clear_inputs();
            rst = ($urandom_range(0, 299) == 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 3) == 0) pulse(i, $urandom);
                if ($urandom_range(0, 79) == 0) bus.req_term[i] = 1'b1;
            end
            tick();
            n_checks++;
            if (bus.out_valid !== m_ov || (m_ov && (bus.out_id !== IW'(m_oid) || bus.out_data !== m_odata))) begin
                n_fail++;
                $display("FAIL rand_out: cycle %0d got v=%b id=%0d data=%h want v=%b id=%0d data=%h",
                         cyc, bus.out_valid, bus.out_id, bus.out_data, m_ov, m_oid, m_odata);
            end
            n_checks++;
            if (bus.req_overflow !== m_ovf || bus.term_count !== CNT_W'(m_tcount) ||
                bus.all_done !== (m_phase == 2)) begin
                n_fail++;
                $display("FAIL rand_status: cycle %0d got ovf=%b tc=%0d done=%b want ovf=%b tc=%0d done=%b",
                         cyc, bus.req_overflow, bus.term_count, bus.all_done, m_ovf, m_tcount, m_phase == 2);
            end
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        bus.out_ready = 1'b0;
        test_reset();
        test_single_latency();
        test_all_cores();
        test_overflow();
        test_back_to_back();
        test_termination();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
